uart_tx_scheduler: RTL
======================

// Module: uart_tx_scheduler
// PURPOSE
//  Round-robin scheduler that shares a single uart_tx among N_REQ byte requesters.
//  Arbitrates pending requests and latches the winner's byte. Pulses start_tx,
//  then tracks the transmitter's busy flag through the frame and reports completion.
//  Sits between client logic and uart_tx. Optionally checks the looped-back
//  uart_rx output against the last byte sent.
// PARAMETERS
//  N_REQ        4   number of requesters (2..8)
//  BUSY_TO      8   max cycles to wait for tx_busy to rise after the start pulse
//  CNT_W        16  width of the frame and error counters
// PORTS
//  clk          in   1          clock
//  reset_n      in   1          async active-low reset
//  req          in   N_REQ      per-requester level request; hold until gnt
//  req_data     in   8*N_REQ    byte for requester i at [8*i+7:8*i]
//  gnt          out  N_REQ      one-hot, 1-cycle pulse: byte i latched
//  done         out  N_REQ      one-hot, 1-cycle pulse: frame for i finished
//  tx_start     out  1          to uart_tx start_tx; 1-cycle pulse
//  tx_data      out  8          to uart_tx data_in; stable from the start pulse to frame end
//  tx_busy      in   1          from uart_tx busy
//  to_err       out  1          1-cycle pulse: tx_busy never rose (timeout)
//  frame_cnt    out  CNT_W      completed frames, wraps at 2^CNT_W
//  rx_data      in   8          from uart_rx data_out (loopback check only)
//  rx_done      in   1          from uart_rx rx_done (loopback check only)
//  lb_mismatch  out  1          1-cycle pulse: loopback byte differs from sent byte
//  lb_err_cnt   out  CNT_W      loopback mismatches, saturates at all-ones
// BEHAVIOUR
//  Reset (async, any state)
//   - state=IDLE; rr_ptr=N_REQ-1, so req[0] has top priority first.
//   - All outputs are 0: gnt, done, tx_start, tx_data, to_err, frame_cnt,
//     lb_mismatch, lb_err_cnt.
//   - A frame in flight is abandoned; no done pulse is issued.
//  FSM states: IDLE -> ISSUE -> WAIT_HI -> WAIT_LO -> IDLE
//   - IDLE, when any req is set and tx_busy=0:
//       - Winner = first set req searching from rr_ptr+1 upward, with modulo wrap.
//       - Latch tx_data and owner; pulse gnt[winner]; set rr_ptr=winner.
//       - Go to ISSUE.
//   - ISSUE: tx_start=1 for exactly this cycle; clear the timeout counter;
//     go to WAIT_HI.
//   - WAIT_HI:
//       - tx_busy=1 -> go to WAIT_LO.
//       - Otherwise count; after BUSY_TO cycles pulse to_err and go to IDLE
//         (no done, frame_cnt unchanged).
//   - WAIT_LO: tx_busy=0 -> pulse done[owner], frame_cnt+1, go to IDLE.
//  Latency and throughput
//   - req to gnt: 1 cycle. gnt to tx_start: 1 cycle.
//   - tx_busy fall to done: 1 cycle.
//   - Back-to-back grant is possible in the cycle after done.
//  Handshake rules
//   - req is sampled only in IDLE. Deasserting req before gnt withdraws the request.
//   - A requester's req_data is not used after its gnt cycle.
//   - A requester holding req after gnt is treated as a new request.
//  Boundary conditions
//   - All req set: strict rotation 0,1,2,...,N_REQ-1,0.
//   - Single requester: it wins every slot.
//   - tx_busy=1 while in IDLE: no grant until it clears.
//   - frame_cnt wraps to 0. lb_err_cnt saturates.
// CONFIGURATION
//  UART_LOOPBACK_CHECK_EN defined:
//   - last_sent is updated at each tx_start.
//   - On rx_done=1, compare rx_data with last_sent. On mismatch: pulse
//     lb_mismatch the next cycle and increment lb_err_cnt.
//   - rx_done in any FSM state is checked.
//  UART_LOOPBACK_CHECK_EN undefined:
//   - rx_data and rx_done are ignored.
//   - lb_mismatch and lb_err_cnt are tied to 0; no check logic is synthesised.
// TESTING
//  1. req=4'b0001, byte 8'hA5, with uart_tx attached
//     -> gnt[0] 1 cycle later; one tx_start pulse; tx serialises A5 LSB-first;
//        done[0] 1 cycle after busy falls; frame_cnt=1.
//  2. req=4'b1111 held, bytes 11/22/33/44
//     -> gnt order 0,1,2,3,0; tx_data sequence 11,22,33,44,11; exactly one
//        tx_start per frame.
//  3. uart_tx replaced by a stub holding busy=0
//     -> to_err pulses BUSY_TO cycles after tx_start; no done; next grant proceeds.
//  4. reset_n low during WAIT_LO of a frame
//     -> all outputs 0 immediately; after release, req[0] is granted before req[3].
//  5. UART_LOOPBACK_CHECK_EN, tx looped to uart_rx
//     -> 8'h3C: no lb_mismatch. Force one rx bit: lb_mismatch pulse, lb_err_cnt=1.
//  6. frame_cnt preloaded to FFFF (CNT_W=16), one frame sent -> frame_cnt=0.

Source files
------------

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler
//
// Purpose:
//   Shares one uart_tx between N_REQ byte requesters using round-robin
//   arbitration. The winning requester's byte is latched and a one-cycle
//   start pulse is sent to the transmitter. The transmitter's busy flag is
//   then followed through the frame, and completion (done) or a start
//   timeout (to_err) is reported.
//
// Optional feature (macro UART_LOOPBACK_CHECK_EN):
//   When this macro is defined, the byte received back from a looped-back
//   uart_rx is compared with the last byte sent. Each mismatch is counted.
//   When the macro is undefined, rx_data and rx_done are ignored, and
//   lb_mismatch and lb_err_cnt are tied to 0.
//
// Parameters:
//   N_REQ    number of requesters (2..8)
//   BUSY_TO  cycles to wait for tx_busy to rise after the start pulse
//   CNT_W    width of the frame and loopback error counters
//
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   req          per-requester level request, held until gnt
//   req_data     byte for requester i at [8*i+7:8*i]
//   gnt          one-hot pulse: byte of requester i latched
//   done         one-hot pulse: frame of requester i finished
//   tx_start     start pulse to uart_tx
//   tx_data      byte to uart_tx, stable for the whole frame
//   tx_busy      busy flag from uart_tx
//   to_err       pulse: tx_busy never rose after the start pulse
//   frame_cnt    completed frames, wraps
//   rx_data      byte from uart_rx (loopback check only)
//   rx_done      byte-valid strobe from uart_rx (loopback check only)
//   lb_mismatch  pulse: looped-back byte differs from the byte sent
//   lb_err_cnt   loopback mismatch count, saturates at all-ones

module uart_tx_scheduler #(
    parameter int N_REQ   = 4,
    parameter int BUSY_TO = 8,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]     gnt,
    output logic [N_REQ-1:0]     done,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 to_err,
    output logic [CNT_W-1:0]     frame_cnt,
    input  logic [7:0]           rx_data,
    input  logic                 rx_done,
    output logic                 lb_mismatch,
    output logic [CNT_W-1:0]     lb_err_cnt
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W  = $clog2(BUSY_TO + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  owner;
    logic [TO_W-1:0]   to_cnt;
    logic [IDX_W-1:0]  winner;
    logic              found;

    // Advance a requester index by 'off' positions, wrapping at N_REQ.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base,
                                                  input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_REQ) begin
            s = s - N_REQ;
        end
        return IDX_W'(s);
    endfunction

    // Search starts at the requester just after the last winner.
    // The last winner is checked last, which gives strict rotation.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            if (!found && req[wrap_idx(rr_ptr, k)]) begin
                found  = 1'b1;
                winner = wrap_idx(rr_ptr, k);
            end
        end
    end

    // All outputs are registered.
    // tx_start is asserted on the cycle after gnt.
    // done is asserted on the cycle after tx_busy falls.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            rr_ptr    <= IDX_W'(N_REQ - 1);
            owner     <= '0;
            to_cnt    <= '0;
            gnt       <= '0;
            done      <= '0;
            tx_start  <= 1'b0;
            tx_data   <= '0;
            to_err    <= 1'b0;
            frame_cnt <= '0;
        end else begin
            gnt      <= '0;
            done     <= '0;
            tx_start <= 1'b0;
            to_err   <= 1'b0;
            case (state)
                IDLE: begin
                    // Wait for the transmitter to be free before granting.
                    if (found && !tx_busy) begin
                        owner       <= winner;
                        rr_ptr      <= winner;
                        tx_data     <= req_data[{winner, 3'b000} +: 8];
                        gnt[winner] <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    tx_start <= 1'b1;
                    to_cnt   <= '0;
                    state    <= WAIT_HI;
                end
                WAIT_HI: begin
                    if (tx_busy) begin
                        state <= WAIT_LO;
                    end else if (to_cnt == TO_W'(BUSY_TO - 1)) begin
                        // Transmitter never accepted the start pulse: abandon the frame.
                        to_err <= 1'b1;
                        state  <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                WAIT_LO: begin
                    if (!tx_busy) begin
                        done[owner] <= 1'b1;
                        frame_cnt   <= frame_cnt + 1'b1;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef UART_LOOPBACK_CHECK_EN
    logic [7:0] last_sent;

    // Capture the byte on its start pulse. tx_data is already stable then.
    // A rx_done in any FSM state is checked against the last byte sent.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_sent   <= '0;
            lb_mismatch <= 1'b0;
            lb_err_cnt  <= '0;
        end else begin
            lb_mismatch <= 1'b0;
            if (tx_start) begin
                last_sent <= tx_data;
            end
            if (rx_done && (rx_data != last_sent)) begin
                lb_mismatch <= 1'b1;
                if (lb_err_cnt != '1) begin
                    lb_err_cnt <= lb_err_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic unused_rx;

    assign unused_rx   = ^{rx_data, rx_done};
    assign lb_mismatch = 1'b0;
    assign lb_err_cnt  = '0;
`endif

endmodule
